uart_tx_buffered: RTL

Buffered UART transmit path for the Basys-3 serial link, the transmit-side counterpart of the receive chain. It accepts bytes from local logic through a write strobe into a small FIFO and serialises them onto `tx` as 8N1 frames, generating its own 16x-oversampled baud tick. The block is self-contained: baud divider, TX FIFO and serialiser FSM all live inside it. Its `tx` output drives the board's UART TX pin directly.

---
 rtl/uart_tx_buffered.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes written through a strobe are queued in
// a small FIFO and serialised LSB first onto a registered tx line. A free-
// running divider produces the 16x oversampled baud tick used by the
// serialiser.
//
// Parameters
//   DBIT     : data bits per frame
//   SB_TICK  : baud ticks in the stop bit (16 / 24 / 32 = 1 / 1.5 / 2 stop bits)
//   DVSR     : clocks per baud tick, f_clk / (16 * baud)
//   DVSR_BIT : width of the divider counter
//   FIFO_W   : FIFO address bits, depth = 2**FIFO_W
//
// Ports
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   wr_uart      : write strobe, enqueues w_data when the FIFO is not full
//   w_data       : byte to enqueue
//   tx           : serial output, idles high
//   tx_full      : FIFO full flag (registered)
//   tx_empty     : FIFO empty flag (registered)
//   tx_busy      : serialiser is not idle
//   tx_done_tick : one-clock pulse as the serialiser returns to idle
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 326,
    parameter int DVSR_BIT = 9,
    parameter int FIFO_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DVSR_BIT-1:0] DVSR_LAST = DVSR_BIT'(DVSR - 1);
    localparam logic [N_W-1:0]      N_LAST    = N_W'(DBIT - 1);
    localparam logic [4:0]          S_BIT_END = 5'd15;
    // The tick counter is 5 bits so the stop bit can run up to 32 ticks.
    localparam logic [4:0]          S_STOP_END = 5'(SB_TICK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- divider
    logic [DVSR_BIT-1:0] r_div_cnt;
    logic                w_tick;

    assign w_tick = (r_div_cnt == DVSR_LAST);

    // Free-running baud divider; never realigned to frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DVSR_BIT'(1);
        end
    end

    // ------------------------------------------------------------------- FIFO
    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wr_ptr;
    logic [FIFO_W-1:0] r_rd_ptr;
    logic [FIFO_W-1:0] w_wr_ptr_inc;
    logic [FIFO_W-1:0] w_rd_ptr_inc;
    logic              r_full;
    logic              r_empty;
    logic              w_full_nxt;
    logic              w_empty_nxt;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_pop;
    logic [DBIT-1:0]   w_fifo_head;

    // Full is judged on the registered flag, so a write into a full FIFO is
    // dropped even when the serialiser pops in the same cycle.
    assign w_wr_en      = wr_uart & ~r_full;
    assign w_rd_en      = w_pop & ~r_empty;
    assign w_wr_ptr_inc = r_wr_ptr + FIFO_W'(1);
    assign w_rd_ptr_inc = r_rd_ptr + FIFO_W'(1);
    assign w_fifo_head  = r_mem[r_rd_ptr];

    // FIFO storage; contents are logically discarded by the pointer reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    // Next full/empty flags; a simultaneous write and pop keeps the count.
    always_comb begin
        w_full_nxt  = r_full;
        w_empty_nxt = r_empty;
        case ({w_wr_en, w_rd_en})
            2'b10: begin
                w_empty_nxt = 1'b0;
                w_full_nxt  = (w_wr_ptr_inc == r_rd_ptr);
            end
            2'b01: begin
                w_full_nxt  = 1'b0;
                w_empty_nxt = (w_rd_ptr_inc == r_wr_ptr);
            end
            default: begin
                w_full_nxt  = r_full;
                w_empty_nxt = r_empty;
            end
        endcase
    end

    // FIFO pointers and flags, all updated on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_en ? w_wr_ptr_inc : r_wr_ptr;
            r_rd_ptr <= w_rd_en ? w_rd_ptr_inc : r_rd_ptr;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
        end
    end

    // ------------------------------------------------------------- serialiser
    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_s;
    logic [4:0]      w_s_nxt;
    logic [N_W-1:0]  r_n;
    logic [N_W-1:0]  w_n_nxt;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_done_nxt;

    // Serialiser state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; tx is derived from the next state so the registered
    // line changes on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_b_nxt     = w_fifo_head;
                    w_s_nxt     = 5'd0;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == S_BIT_END) begin
                        w_s_nxt     = 5'd0;
                        w_n_nxt     = '0;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end else begin
                    w_s_nxt = r_s;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == S_BIT_END) begin
                        w_s_nxt = 5'd0;
                        w_b_nxt = r_b >> 1;
                        if (r_n == N_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_n_nxt = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end else begin
                    w_s_nxt = r_s;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP_END) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end else begin
                    w_s_nxt = r_s;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_IDLE:  w_tx_nxt = 1'b1;
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_b_nxt[0];
            ST_STOP:  w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_full      = r_full;
    assign tx_empty     = r_empty;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule
